// File: rtl/ehl_clock_div_ctrl.sv
// Glitch-free programmable clock divider: clk_out toggles every cur_div+1 clk_in cycles.
// Ratio changes wait for clk_out low, gate it for GAP_CYCLES, then restart at the new value.
module ehl_clock_div_ctrl #(
  parameter int DIV_W      = 8,
  parameter int DIV_INIT   = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [DIV_W-1:0] req_div,
  output logic             req_ready,
  output logic             clk_out,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, GATED} state_t;

  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_INIT);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] pending, pending_nxt;
  logic [DIV_W-1:0] cur_div_nxt;
  logic [3:0]       gap_cnt, gap_nxt;
  logic             clk_out_nxt, done_nxt;
  logic             handshake, wrap, run_clk;
  logic [DIV_W-1:0] run_cnt;

  assign req_ready = (state == IDLE) && reset_n;
  assign busy      = (state != IDLE);
  assign handshake = req_valid && req_ready;

  // Free-running half-period counter values, used whenever the divider is not gated.
  assign wrap    = (cnt == cur_div);
  assign run_cnt = wrap ? '0 : cnt + DIV_W'(1);
  assign run_clk = wrap ? ~clk_out : clk_out;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    clk_out_nxt = clk_out;
    cur_div_nxt = cur_div;
    pending_nxt = pending;
    gap_nxt     = gap_cnt;
    done_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (handshake) begin
          pending_nxt = req_div;
          if (clk_out) begin
            state_nxt   = WAIT_LOW;
            cnt_nxt     = run_cnt;
            clk_out_nxt = run_clk;
          end else begin
            // Already low: freeze here so clk_out cannot rise into the gate.
            state_nxt = GATED;
            gap_nxt   = '0;
          end
        end else begin
          cnt_nxt     = run_cnt;
          clk_out_nxt = run_clk;
        end
      end
      WAIT_LOW: begin
        cnt_nxt     = run_cnt;
        clk_out_nxt = run_clk;
        if (wrap && clk_out) begin
          state_nxt = GATED;
          gap_nxt   = '0;
        end
      end
      GATED: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          cur_div_nxt = pending;
          cnt_nxt     = '0;
          done_nxt    = 1'b1;
        end else begin
          gap_nxt = gap_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      clk_out <= 1'b0;
      cur_div <= DIV_RST;
      pending <= DIV_RST;
      gap_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      clk_out <= clk_out_nxt;
      cur_div <= cur_div_nxt;
      pending <= pending_nxt;
      gap_cnt <= gap_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ehl_clock_div_ctrl.sv
// Directed and table-driven bench for ehl_clock_div_ctrl with a phase-length monitor.
module tb_ehl_clock_div_ctrl;
  localparam int DIV_W    = 8;
  localparam int DIV_INIT = 1;
  localparam int GAP      = 2;

  logic             clk_in = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic [DIV_W-1:0] req_div;
  logic             req_ready;
  logic             clk_out;
  logic [DIV_W-1:0] cur_div;
  logic             busy;
  logic             done;

  ehl_clock_div_ctrl #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT), .GAP_CYCLES(GAP)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .req_valid(req_valid), .req_div(req_div),
    .req_ready(req_ready), .clk_out(clk_out), .cur_div(cur_div), .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs and pre-edge ready captured at each rising edge for the monitor.
  logic             hs_q  = 1'b0;
  logic             rst_q = 1'b0;
  logic [DIV_W-1:0] req_q = '0;
  always @(posedge clk_in) begin
    hs_q  <= req_valid && req_ready;
    rst_q <= reset_n;
    req_q <= req_div;
  end

  int   cyc = 0, done_cnt = 0, ph_len = 0, ph_min = DIV_INIT;
  int   hi_last = 0, lo_last = 0, mdl_cur = DIV_INIT, mdl_pend = DIV_INIT;
  bit   ph_ok = 1'b0;
  logic ph_val = 1'b0;

  // Every complete clk_out phase must last at least min(D in effect)+1 cycles.
  always @(negedge clk_in) begin
    cyc++;
    if (!rst_q) begin
      ph_ok = 1'b0; ph_len = 0; ph_val = clk_out;
      mdl_cur = DIV_INIT; mdl_pend = DIV_INIT; ph_min = DIV_INIT;
    end else begin
      if (hs_q) begin
        mdl_pend = int'(req_q);
        if (mdl_pend < ph_min) ph_min = mdl_pend;
      end
      if (clk_out !== ph_val) begin
        if (ph_ok) begin
          n_tests++;
          if (ph_len < ph_min + 1) begin
            n_fail++;
            $display("FAIL glitch_phase: level %0d lasted %0d cycles, needs at least %0d at cycle %0d",
                     ph_val, ph_len, ph_min + 1, cyc);
          end
        end
        if (ph_val) hi_last = ph_len; else lo_last = ph_len;
        ph_ok = 1'b1; ph_len = 1; ph_val = clk_out; ph_min = mdl_cur;
      end else begin
        ph_len++;
      end
      if (done) begin
        mdl_cur = mdl_pend;
        if (mdl_cur < ph_min) ph_min = mdl_cur;
        done_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wait_val(input logic v, input string name);
    int n = 0;
    while (clk_out !== v && n < 200) begin
      tick();
      n++;
    end
    if (clk_out !== v) chk({name, "_timeout"}, int'(clk_out), int'(v));
  endtask

  // Lands exactly on the edge where clk_out has just become v.
  task automatic fresh(input logic v);
    wait_val(~v, "fresh_a");
    wait_val(v, "fresh_b");
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(name, int'(done), 1);
  endtask

  typedef struct {
    logic [DIV_W-1:0] d;
    logic             start_high;
    int               exp_half;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    int   d0, hs, e, errs, n, nreq, last_d;
    bit   acc;

    vecs[0] = '{d: 8'd2, start_high: 1'b1, exp_half: 3};
    vecs[1] = '{d: 8'd2, start_high: 1'b0, exp_half: 3};
    vecs[2] = '{d: 8'd0, start_high: 1'b0, exp_half: 1};
    vecs[3] = '{d: 8'd7, start_high: 1'b0, exp_half: 8};
    vecs[4] = '{d: 8'd4, start_high: 1'b1, exp_half: 5};

    // Reset held 5 cycles with a request offered that must be ignored.
    reset_n = 1'b0; req_valid = 1'b1; req_div = 8'd7;
    repeat (5) tick();
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cur_div", int'(cur_div), DIV_INIT);
    chk("rst_busy", int'(busy), 0);
    req_valid = 1'b0; reset_n = 1'b1;
    tick();
    chk("rel_edge1_clk", int'(clk_out), 0);
    tick();
    chk("rel_edge2_clk", int'(clk_out), 1);
    errs = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (clk_out !== ((k % 4) == 0 || (k % 4) == 1)) errs++;
    end
    chk("div4_pattern_errs", errs, 0);

    // D=3 accepted while high: old high phase completes, low = gap + 4.
    fresh(1'b1);
    d0 = done_cnt;
    req_valid = 1'b1; req_div = 8'd3;
    tick();
    req_valid = 1'b0;
    chk("a_busy", int'(busy), 1);
    chk("a_still_high", int'(clk_out), 1);
    wait_val(1'b0, "a_fall");
    chk("a_high_len", hi_last, 2);
    wait_val(1'b1, "a_rise");
    chk("a_low_len", lo_last, GAP + 4);
    chk("a_done_cnt", done_cnt - d0, 1);
    chk("a_cur_div", int'(cur_div), 3);
    wait_val(1'b0, "a_fall2");
    chk("a_high_new", hi_last, 4);
    wait_val(1'b1, "a_rise2");
    chk("a_low_new", lo_last, 4);

    // D=0 accepted two cycles into a low phase: low stretched to 2 + 1 + gap + 1.
    fresh(1'b0);
    tick(); tick();
    d0 = done_cnt;
    req_valid = 1'b1; req_div = 8'd0;
    tick();
    hs = cyc;
    req_valid = 1'b0;
    chk("b_busy", int'(busy), 1);
    chk("b_held_low", int'(clk_out), 0);
    wait_val(1'b1, "b_rise");
    chk("b_rise_delay", cyc - hs, GAP + 1);
    chk("b_low_len", lo_last, 6);
    wait_val(1'b0, "b_fall");
    chk("b_high_new", hi_last, 1);
    wait_val(1'b1, "b_rise2");
    chk("b_low_new", lo_last, 1);
    chk("b_done_cnt", done_cnt - d0, 1);
    chk("b_cur_div", int'(cur_div), 0);

    // Back-to-back requests: the second is stalled, then taken while done pulses.
    fresh(1'b0);
    d0 = done_cnt;
    req_valid = 1'b1; req_div = 8'd2;
    tick();
    chk("c_busy1", int'(busy), 1);
    req_div = 8'd5;
    errs = 0; n = 0;
    while (done !== 1'b1 && n < 50) begin
      if (req_ready) errs++;
      tick();
      n++;
    end
    chk("c_stall_ready", errs, 0);
    chk("c_done1", int'(done), 1);
    chk("c_cur_div1", int'(cur_div), 2);
    chk("c_ready_at_done", int'(req_ready), 1);
    tick();
    hs = cyc;
    req_valid = 1'b0;
    chk("c_busy2", int'(busy), 1);
    chk("c_done_one_cycle", int'(done), 0);
    wait_done("c_done2");
    chk("c_gap_len", cyc - hs, GAP);
    chk("c_cur_div2", int'(cur_div), 5);
    e = cyc;
    wait_val(1'b1, "c_rise");
    chk("c_first_rise", cyc - e, 6);
    wait_val(1'b0, "c_fall");
    chk("c_high", hi_last, 6);
    wait_val(1'b1, "c_rise2");
    chk("c_low", lo_last, 6);
    chk("c_done_cnt", done_cnt - d0, 2);

    // Reset while gated discards the pending value without a done pulse.
    fresh(1'b0);
    d0 = done_cnt;
    req_valid = 1'b1; req_div = 8'd4;
    tick();
    req_valid = 1'b0;
    chk("d_busy", int'(busy), 1);
    reset_n = 1'b0;
    tick();
    chk("d_clk_out", int'(clk_out), 0);
    chk("d_cur_div", int'(cur_div), DIV_INIT);
    chk("d_busy_clr", int'(busy), 0);
    chk("d_done", int'(done), 0);
    chk("d_ready", int'(req_ready), 0);
    repeat (4) tick();
    chk("d_no_done", done_cnt - d0, 0);
    reset_n = 1'b1;
    tick(); tick();
    chk("d_rise_after_rel", int'(clk_out), 1);
    chk("d_cur_div_after", int'(cur_div), DIV_INIT);

    // Table of ratio changes from either clk_out level, including a same-value request.
    for (int i = 0; i < 5; i++) begin
      fresh(vecs[i].start_high);
      d0 = done_cnt;
      req_valid = 1'b1; req_div = vecs[i].d;
      tick();
      req_valid = 1'b0;
      wait_done($sformatf("v%0d_done", i));
      e = cyc;
      chk($sformatf("v%0d_cur_div", i), int'(cur_div), int'(vecs[i].d));
      tick();
      chk($sformatf("v%0d_done_pulse_len", i), int'(done), 0);
      wait_val(1'b1, "v_rise");
      chk($sformatf("v%0d_first_rise", i), cyc - e, vecs[i].exp_half);
      wait_val(1'b0, "v_fall");
      chk($sformatf("v%0d_high", i), hi_last, vecs[i].exp_half);
      wait_val(1'b1, "v_rise2");
      chk($sformatf("v%0d_low", i), lo_last, vecs[i].exp_half);
      chk($sformatf("v%0d_done_cnt", i), done_cnt - d0, 1);
    end

    // Random requests at random times; the monitor checks every phase.
    d0 = done_cnt; nreq = 0; last_d = int'(cur_div);
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 8)) tick();
      req_div = DIV_W'($urandom_range(0, 5));
      req_valid = 1'b1;
      acc = 1'b0; n = 0;
      while (!acc && n < 100) begin
        acc = req_ready;
        tick();
        n++;
      end
      chk("rand_accept", int'(acc), 1);
      if (acc) begin
        nreq++;
        last_d = int'(req_div);
      end
      req_valid = 1'b0;
    end
    repeat (40) tick();
    chk("rand_done_cnt", done_cnt - d0, nreq);
    chk("rand_cur_div", int'(cur_div), last_d);
    chk("rand_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ehl_clock_div_ctrl.md
EHL_CLOCK_DIV_CTRL -- requirements
Module: ehl_clock_div_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, giving the width of the divide-value field.
REQ-002 The block SHALL have parameter DIV_INIT, default 1, giving the divide value loaded at reset.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, range 1..15, giving the number of clk_in cycles clk_out is held low during a ratio switch.
REQ-004 Port clk_in, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 Port req_valid, input, 1 bit: new divide value offered.
REQ-007 Port req_div, input, DIV_W bits: requested divide value D.
REQ-008 Port req_ready, output, 1 bit: block can accept a request.
REQ-009 Port clk_out, output, 1 bit: registered divided clock.
REQ-010 Port cur_div, output, DIV_W bits: divide value currently in effect.
REQ-011 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse when a new value takes effect.

Function
REQ-013 Half-period counter cnt SHALL increment each cycle while running; when cnt==cur_div, clk_out toggles and cnt wraps to 0.
REQ-014 Output period SHALL therefore be 2*(cur_div+1) clk_in cycles; D=0 gives divide-by-2.
REQ-015 The FSM SHALL have exactly the states IDLE, WAIT_LOW and GATED.
REQ-016 req_ready SHALL equal (state==IDLE) and reset_n, and is combinational from registered state.
REQ-017 A handshake SHALL occur when req_valid and req_ready are both 1 on a rising edge; req_div is then captured into a pending register.
REQ-018 On a handshake with clk_out==1, the FSM SHALL enter WAIT_LOW.
REQ-019 On a handshake with clk_out==0, the FSM SHALL enter GATED directly.
REQ-020 In WAIT_LOW, the counter SHALL keep running at the old cur_div; on the edge where clk_out toggles 1->0, the FSM SHALL enter GATED.
REQ-021 In GATED, clk_out SHALL be held 0, cnt held, and a gap counter SHALL count GAP_CYCLES cycles.
REQ-022 On GATED exit, the block SHALL in the same edge: set cur_div to the pending value, set cnt to 0, return to IDLE, and assert done for exactly one cycle.
REQ-023 After GATED exit, the first clk_out rise SHALL occur new_D+1 cycles later.
REQ-024 No clk_out high or low phase SHALL ever be shorter than (min(old_D,new_D)+1) cycles (glitch-free).
REQ-025 A request equal to cur_div SHALL still run the full sequence and pulse done.
REQ-026 req_valid asserted while busy SHALL be stalled (req_ready=0), not dropped; it is accepted on the first IDLE cycle.
REQ-027 A request presented in the same cycle that done pulses SHALL be accepted on the next edge, since the FSM is IDLE from that edge onward.

Reset
REQ-028 While reset_n==0 at a rising edge, the block SHALL set: state=IDLE, clk_out=0, cnt=0, gap counter=0, cur_div=DIV_INIT, pending=DIV_INIT, done=0, busy=0.
REQ-029 While reset_n==0, req_ready SHALL be 0 and requests SHALL be ignored.
REQ-030 Reset asserted mid-operation (WAIT_LOW or GATED) SHALL discard the pending value with no done pulse.
REQ-031 After reset release, with DIV_INIT=1, clk_out SHALL rise on the 2nd rising edge.

Verification
REQ-032 The bench SHALL cover: reset held 5 cycles -> clk_out=0, req_ready=0, done=0, cur_div=1; after release, clk_out period is 4 cycles for 40 cycles.
REQ-033 The bench SHALL cover: request D=3 accepted while clk_out=1 -> high phase completes at 2 cycles, low lasts 2+4=6 cycles, then period is 8; exactly one done pulse; cur_div=3.
REQ-034 The bench SHALL cover: request D=0 accepted while clk_out=0 -> low phase extended by 2 gap cycles plus 1, then period is 2; done pulses once.
REQ-035 The bench SHALL cover: second request D=5 held valid during busy -> req_ready=0 until the first done, then accepted; both done pulses seen; final period is 12.
REQ-036 The bench SHALL cover: reset asserted during GATED -> next cycle clk_out=0, cur_div=DIV_INIT, busy=0, no done pulse.
REQ-037 The bench SHALL run a free-running random-request checker that asserts REQ-024 on every clk_out phase.
